// File: rtl/mos6502s_interrupt_sequencer_if.sv
// Bus bundle between the control side and the interrupt sequencer.
// Carries the request/status inputs, the captured PC/SP/P values and the
// memory/stack/PC load outputs. The master modport is the driver (control
// unit / memory model); the slave modport is the sequencer itself.
interface mos6502s_interrupt_sequencer_if;
  logic        boundary;
  logic        brk_req;
  logic        irq_n;
  logic        nmi_n;
  logic        i_flag;
  logic [15:0] pc_in;
  logic [7:0]  sp_in;
  logic [7:0]  p_in;
  logic [7:0]  mem_rdata;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  sp_out;
  logic        sp_load;
  logic        set_i;
  logic [15:0] pc_out;
  logic        pc_load;
  logic        busy;
  logic        done;
  logic [1:0]  kind;

  modport master (
    output boundary, brk_req, irq_n, nmi_n, i_flag, pc_in, sp_in, p_in, mem_rdata,
    input  addr, wdata, we, sp_out, sp_load, set_i, pc_out, pc_load, busy, done, kind
  );

  modport slave (
    input  boundary, brk_req, irq_n, nmi_n, i_flag, pc_in, sp_in, p_in, mem_rdata,
    output addr, wdata, we, sp_out, sp_load, set_i, pc_out, pc_load, busy, done, kind
  );
endinterface

// File: rtl/mos6502s_interrupt_sequencer.sv
// Purpose: pushes PCH, PCL, P for BRK/IRQ/NMI, then fetches the handler vector.
// Latency: request at a boundary in cycle 0, pushes in cycles 1-3, vector reads 4-5, done in 6.
// Backpressure: none; boundary is ignored while busy, a new start is allowed in the done cycle.
//
// Ports: clk, rst (async, active high) plus the slave side of
// mos6502s_interrupt_sequencer_if: request inputs (boundary, brk_req, irq_n,
// nmi_n, i_flag), captured values (pc_in, sp_in, p_in), memory read data, and
// the memory address/write strobe, stack/PC load, set_i, busy/done/kind outputs.
// Optional feature: define MOS6502S_NMI_HIJACK_EN to let a pending NMI take
// over the vector fetch of a BRK/IRQ sequence.
module mos6502s_interrupt_sequencer #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
  input  logic                            clk,
  input  logic                            rst,
  mos6502s_interrupt_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_LO,
    VEC_HI
  } state_t;

  localparam logic [1:0] KIND_IDLE = 2'd0;
  localparam logic [1:0] KIND_BRK  = 2'd1;
  localparam logic [1:0] KIND_IRQ  = 2'd2;
  localparam logic [1:0] KIND_NMI  = 2'd3;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  sp_q, sp_d;
  logic [7:0]  p_q, p_d;
  logic [1:0]  kind_q, kind_d;
  logic        vec_nmi_q, vec_nmi_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        done_q, done_d;
  logic        nmi_n_q;
  logic        nmi_pending_q, nmi_pending_d;

  logic        nmi_fall;
  logic        irq_req;
  logic        start;
  logic        use_nmi_vec;
  logic [15:0] vec_base;
  logic [7:0]  p_push;

  logic [15:0] addr_c;
  logic [7:0]  wdata_c;
  logic        we_c;
  logic        set_i_c;

  assign nmi_fall = nmi_n_q & ~bus.nmi_n;
  assign irq_req  = ~bus.irq_n & ~bus.i_flag;
  assign start    = (state_q == IDLE) & bus.boundary &
                    (bus.brk_req | nmi_pending_q | irq_req);

  // Vector choice is made while in PUSH_P and frozen into vec_nmi_q on the
  // edge into VEC_LO, so a later NMI edge cannot split the two vector reads.
`ifdef MOS6502S_NMI_HIJACK_EN
  assign use_nmi_vec = nmi_pending_q | (kind_q == KIND_NMI);
`else
  assign use_nmi_vec = (kind_q == KIND_NMI);
`endif

  assign vec_base = vec_nmi_q ? VEC_NMI : VEC_IRQ;

  // Unused bit 5 is forced to 1; B (bit 4) is 1 only for BRK, even if hijacked.
  assign p_push = ((p_q | 8'h20) & 8'hEF) | {3'b000, (kind_q == KIND_BRK), 4'b0000};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    p_d       = p_q;
    kind_d    = kind_q;
    vec_nmi_d = vec_nmi_q;
    pc_out_d  = pc_out_q;
    done_d    = 1'b0;
    addr_c    = 16'h0000;
    wdata_c   = 8'h00;
    we_c      = 1'b0;
    set_i_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PUSH_PCH;
          pc_d    = bus.pc_in;
          sp_d    = bus.sp_in;
          p_d     = bus.p_in;
          if (bus.brk_req)    kind_d = KIND_BRK;
          else if (nmi_pending_q) kind_d = KIND_NMI;
          else                kind_d = KIND_IRQ;
        end
      end
      PUSH_PCH: begin
        addr_c  = {STACK_PAGE, sp_q};
        wdata_c = pc_q[15:8];
        we_c    = 1'b1;
        sp_d    = sp_q - 8'd1;
        state_d = PUSH_PCL;
      end
      PUSH_PCL: begin
        addr_c  = {STACK_PAGE, sp_q};
        wdata_c = pc_q[7:0];
        we_c    = 1'b1;
        sp_d    = sp_q - 8'd1;
        state_d = PUSH_P;
      end
      PUSH_P: begin
        addr_c    = {STACK_PAGE, sp_q};
        wdata_c   = p_push;
        we_c      = 1'b1;
        set_i_c   = 1'b1;
        sp_d      = sp_q - 8'd1;
        vec_nmi_d = use_nmi_vec;
        state_d   = VEC_LO;
      end
      VEC_LO: begin
        addr_c         = vec_base;
        pc_out_d[7:0]  = bus.mem_rdata;
        state_d        = VEC_HI;
      end
      VEC_HI: begin
        addr_c         = vec_base + 16'd1;
        pc_out_d[15:8] = bus.mem_rdata;
        done_d         = 1'b1;
        kind_d         = KIND_IDLE;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
        kind_d  = KIND_IDLE;
      end
    endcase
  end

  // Pending is consumed on the edge into VEC_LO when the NMI vector is used;
  // a fresh falling edge on that same edge wins so it is never lost.
  always_comb begin
    nmi_pending_d = nmi_pending_q;
    if ((state_q == PUSH_P) && use_nmi_vec) nmi_pending_d = 1'b0;
    if (nmi_fall) nmi_pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= 16'h0000;
      sp_q          <= 8'h00;
      p_q           <= 8'h00;
      kind_q        <= KIND_IDLE;
      vec_nmi_q     <= 1'b0;
      pc_out_q      <= 16'h0000;
      done_q        <= 1'b0;
      nmi_n_q       <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      sp_q          <= sp_d;
      p_q           <= p_d;
      kind_q        <= kind_d;
      vec_nmi_q     <= vec_nmi_d;
      pc_out_q      <= pc_out_d;
      done_q        <= done_d;
      nmi_n_q       <= bus.nmi_n;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign bus.addr    = addr_c;
  assign bus.wdata   = wdata_c;
  assign bus.we      = we_c;
  assign bus.set_i   = set_i_c;
  assign bus.sp_out  = sp_q;
  assign bus.sp_load = done_q;
  assign bus.pc_out  = pc_out_q;
  assign bus.pc_load = done_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.kind    = kind_q;

endmodule

// File: tb/tb_mos6502s_interrupt_sequencer.sv
// Directed bench for mos6502s_interrupt_sequencer: BRK, IRQ masking and
// back-to-back start, NMI edge detection, NMI hijack (both builds, chosen by
// MOS6502S_NMI_HIJACK_EN), stack pointer wrap and reset mid-sequence.
module tb_mos6502s_interrupt_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mos6502s_interrupt_sequencer_if bus();

  mos6502s_interrupt_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector memory: IRQ/BRK handler at 8000, NMI handler at 9000.
  always_comb begin
    case (bus.addr)
      16'hFFFA: bus.mem_rdata = 8'h00;
      16'hFFFB: bus.mem_rdata = 8'h90;
      16'hFFFE: bus.mem_rdata = 8'h00;
      16'hFFFF: bus.mem_rdata = 8'h80;
      default:  bus.mem_rdata = 8'hEE;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in cycle 0 with the request already driven; returns in the done cycle.
  task automatic expect_seq(input string name, input logic [15:0] pc, input logic [7:0] sp,
                            input logic [7:0] pp, input logic [15:0] vec, input logic [15:0] vval,
                            input logic [1:0] k, input int nmi_at);
    logic [7:0]  s;
    logic [15:0] v1;
    s  = sp;
    v1 = vec + 16'd1;
    tick();
    bus.boundary = 1'b0;
    bus.brk_req  = 1'b0;
    bus.irq_n    = 1'b1;
    if (nmi_at == 1) bus.nmi_n = 1'b0;
    chk({name, ":pch"}, {bus.we, bus.set_i, bus.busy, bus.kind, bus.addr, bus.wdata},
        {1'b1, 1'b0, 1'b1, k, 8'h01, s, pc[15:8]});
    s = s - 8'd1;
    tick();
    if (nmi_at == 2) bus.nmi_n = 1'b0;
    chk({name, ":pcl"}, {bus.we, bus.set_i, bus.busy, bus.kind, bus.addr, bus.wdata},
        {1'b1, 1'b0, 1'b1, k, 8'h01, s, pc[7:0]});
    s = s - 8'd1;
    tick();
    if (nmi_at == 3) bus.nmi_n = 1'b0;
    chk({name, ":p"}, {bus.we, bus.set_i, bus.busy, bus.kind, bus.addr, bus.wdata},
        {1'b1, 1'b1, 1'b1, k, 8'h01, s, pp});
    s = s - 8'd1;
    tick();
    chk({name, ":veclo"}, {bus.we, bus.set_i, bus.busy, bus.kind, bus.addr},
        {1'b0, 1'b0, 1'b1, k, vec});
    tick();
    chk({name, ":vechi"}, {bus.we, bus.set_i, bus.busy, bus.kind, bus.addr},
        {1'b0, 1'b0, 1'b1, k, v1});
    tick();
    chk({name, ":done"}, {bus.done, bus.pc_load, bus.sp_load, bus.busy, bus.kind, bus.we},
        {1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0});
    chk({name, ":pc_out"}, {16'h0, bus.pc_out}, {16'h0, vval});
    chk({name, ":sp_out"}, {24'h0, bus.sp_out}, {24'h0, s});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst          = 1'b1;
    bus.boundary = 1'b0;
    bus.brk_req  = 1'b0;
    bus.irq_n    = 1'b1;
    bus.nmi_n    = 1'b1;
    bus.i_flag   = 1'b0;
    bus.pc_in    = 16'h0000;
    bus.sp_in    = 8'h00;
    bus.p_in     = 8'h00;

    // Reset state
    #12;
    chk("reset_outputs", {bus.addr, bus.wdata, bus.we, bus.sp_load, bus.set_i, bus.pc_load,
                          bus.busy, bus.done, bus.kind},
        32'h0);
    chk("reset_pc_sp", {bus.pc_out, bus.sp_out, 8'h00}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Boundary with no request stays idle
    bus.boundary = 1'b1;
    tick();
    chk("idle_no_req", {31'h0, bus.busy}, 32'h0);

    // BRK
    bus.brk_req = 1'b1;
    bus.sp_in   = 8'hFD;
    bus.pc_in   = 16'h1234;
    bus.p_in    = 8'h00;
    expect_seq("brk", 16'h1234, 8'hFD, 8'h30, 16'hFFFE, 16'h8000, 2'd1, 0);
    tick();
    chk("brk_done_pulse", {30'h0, bus.done, bus.busy}, 32'h0);

    // IRQ masked by I flag
    bus.irq_n    = 1'b0;
    bus.i_flag   = 1'b1;
    bus.boundary = 1'b1;
    tick();
    chk("irq_masked", {31'h0, bus.busy}, 32'h0);

    // IRQ taken, pushed P gets bit 5 set and B clear
    bus.i_flag = 1'b0;
    bus.pc_in  = 16'h4000;
    bus.sp_in  = 8'hFA;
    bus.p_in   = 8'h18;
    expect_seq("irq", 16'h4000, 8'hFA, 8'h28, 16'hFFFE, 16'h8000, 2'd2, 0);

    // Back-to-back: new IRQ starts in the done cycle
    bus.boundary = 1'b1;
    bus.irq_n    = 1'b0;
    bus.pc_in    = 16'h5678;
    bus.sp_in    = 8'hF7;
    bus.p_in     = 8'h00;
    expect_seq("irq_b2b", 16'h5678, 8'hF7, 8'h20, 16'hFFFE, 16'h8000, 2'd2, 0);

    // IRQ is not latched
    tick();
    bus.irq_n = 1'b0;
    tick();
    bus.irq_n    = 1'b1;
    bus.boundary = 1'b1;
    tick();
    chk("irq_not_latched", {31'h0, bus.busy}, 32'h0);
    bus.boundary = 1'b0;

    // NMI edge, held low across later boundaries: exactly one sequence
    bus.nmi_n = 1'b0;
    tick();
    tick();
    bus.boundary = 1'b1;
    bus.pc_in    = 16'hABCD;
    bus.sp_in    = 8'hF0;
    bus.p_in     = 8'hC3;
    expect_seq("nmi1", 16'hABCD, 8'hF0, 8'hE3, 16'hFFFA, 16'h9000, 2'd3, 0);
    bus.boundary = 1'b1;
    tick();
    chk("nmi_held_1", {31'h0, bus.busy}, 32'h0);
    tick();
    chk("nmi_held_2", {31'h0, bus.busy}, 32'h0);
    bus.boundary = 1'b0;

    // Second falling edge gives a second NMI sequence
    bus.nmi_n = 1'b1;
    tick();
    bus.nmi_n = 1'b0;
    tick();
    tick();
    bus.boundary = 1'b1;
    bus.pc_in    = 16'h0102;
    bus.sp_in    = 8'hE0;
    bus.p_in     = 8'h00;
    expect_seq("nmi2", 16'h0102, 8'hE0, 8'h20, 16'hFFFA, 16'h9000, 2'd3, 0);
    bus.nmi_n = 1'b1;
    tick();
    tick();

    // NMI edge during PUSH_PCL of an IRQ sequence
    bus.boundary = 1'b1;
    bus.irq_n    = 1'b0;
    bus.pc_in    = 16'h2222;
    bus.sp_in    = 8'hD0;
    bus.p_in     = 8'h00;
`ifdef MOS6502S_NMI_HIJACK_EN
    expect_seq("hijack", 16'h2222, 8'hD0, 8'h20, 16'hFFFA, 16'h9000, 2'd2, 2);
    bus.boundary = 1'b1;
    tick();
    chk("hijack_consumed", {31'h0, bus.busy}, 32'h0);
    bus.boundary = 1'b0;
`else
    expect_seq("no_hijack", 16'h2222, 8'hD0, 8'h20, 16'hFFFE, 16'h8000, 2'd2, 2);
    bus.boundary = 1'b1;
    bus.pc_in    = 16'h3333;
    bus.sp_in    = 8'hCD;
    bus.p_in     = 8'h00;
    expect_seq("late_nmi", 16'h3333, 8'hCD, 8'h20, 16'hFFFA, 16'h9000, 2'd3, 0);
`endif
    bus.nmi_n = 1'b1;
    tick();
    tick();

    // Stack pointer wraps within the stack page
    bus.boundary = 1'b1;
    bus.brk_req  = 1'b1;
    bus.pc_in    = 16'hBEEF;
    bus.sp_in    = 8'h01;
    bus.p_in     = 8'h04;
    expect_seq("wrap", 16'hBEEF, 8'h01, 8'h34, 16'hFFFE, 16'h8000, 2'd1, 0);
    tick();

    // Reset during PUSH_P with an NMI pending
    bus.nmi_n = 1'b0;
    tick();
    tick();
    bus.boundary = 1'b1;
    bus.brk_req  = 1'b1;
    bus.sp_in    = 8'h80;
    bus.pc_in    = 16'h7777;
    tick();
    bus.boundary = 1'b0;
    bus.brk_req  = 1'b0;
    tick();
    tick();
    chk("pre_reset_push_p", {30'h0, bus.we, bus.set_i}, 32'h3);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_async", {bus.addr, bus.wdata, bus.we, bus.set_i, bus.busy, bus.done, bus.kind, 2'b00},
        32'h0);
    chk("reset_async_regs", {bus.pc_out, bus.sp_out, 8'h00}, 32'h0);
    bus.nmi_n = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_reset_quiet", {29'h0, bus.done, bus.busy, bus.we}, 32'h0);
    end
    bus.boundary = 1'b1;
    tick();
    chk("nmi_lost", {31'h0, bus.busy}, 32'h0);
    bus.boundary = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mos6502s_interrupt_sequencer.md
# mos6502s_interrupt_sequencer

Stack-push and vector-fetch sequencer for the mos6502s core. It is the write-side counterpart of the status register: where the status register loads P from the data bus on PLP/RTI, this block pushes PCH, PCL and P onto the stack for BRK, IRQ and NMI, then fetches the handler vector. It sits between the control unit, the stack pointer, the status register (driving its `load_i`/`i_in`) and the memory bus.

## Interface
Parameters:
- `STACK_PAGE`, default 8'h01: high address byte for stack accesses.
- `VEC_NMI`, default 16'hFFFA: NMI vector low-byte address.
- `VEC_IRQ`, default 16'hFFFE: IRQ/BRK vector low-byte address.

Ports:
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `boundary` input 1: the control unit is at an instruction boundary this cycle.
- `brk_req` input 1: BRK opcode decoded; sampled only with `boundary`.
- `irq_n` input 1: level-sensitive IRQ, active low.
- `nmi_n` input 1: NMI, active low, falling-edge sensitive.
- `i_flag` input 1: current I flag.
- `pc_in` input 16: PC to push; the control unit supplies it already adjusted.
- `sp_in` input 8: stack pointer, captured at sequence start.
- `p_in` input 8: status register value, captured at sequence start.
- `mem_rdata` input 8: read data, valid in the same cycle as `addr`.
- `addr` output 16: memory address.
- `wdata` output 8: write data.
- `we` output 1: write strobe.
- `sp_out` output 8: working stack pointer.
- `sp_load` output 1: pulses with `done`; the stack pointer loads `sp_out`.
- `set_i` output 1: drives status register `load_i` with `i_in`=1.
- `pc_out` output 16: fetched vector.
- `pc_load` output 1: pulses with `done`.
- `busy` output 1: sequence in progress.
- `done` output 1: one-cycle completion pulse.
- `kind` output 2: type of the active sequence (0 idle, 1 BRK, 2 IRQ, 3 NMI).

## Operation
- State machine states: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI.
- **Start.** The sequence starts in IDLE when `boundary`=1 and at least one of these holds: `brk_req`; `nmi_pending`; `irq_n`=0 with `i_flag`=0.
  - Priority is BRK > NMI > IRQ.
  - At start the block captures `pc_in`, `sp_in` and `p_in`, sets `kind`, and moves to PUSH_PCH.
  - `boundary` with no request leaves the block in IDLE.
- **PUSH_PCH.** `addr`={STACK_PAGE,sp}, `wdata`=PC[15:8], `we`=1. The stack pointer decrements at the edge.
- **PUSH_PCL.** Same access pattern, with `wdata`=PC[7:0].
- **PUSH_P.** Same access pattern, with `wdata`=(P | 8'h20), bit 4 set to 1 for BRK and 0 for IRQ/NMI.
  - `set_i`=1 in this cycle.
- **Stack pointer width.** Decrements are 8-bit and wrap from 8'h00 to 8'hFF. The stack page never changes.
- **VEC_LO.** `addr`=selected vector and `we`=0. `mem_rdata` is captured into `pc_out[7:0]`.
- **VEC_HI.** `addr`=vector+1 and `we`=0. `mem_rdata` is captured into `pc_out[15:8]`.
  - `done`, `pc_load` and `sp_load` pulse for one cycle on the edge leaving VEC_HI.
  - The next state is IDLE.
- **Vector selection (NMI hijack).** The vector is fixed on entry to VEC_LO. If `nmi_pending` is set at that moment, the block uses VEC_NMI; otherwise it uses VEC_IRQ (or VEC_NMI for an NMI sequence).
  - Entering VEC_LO with the NMI vector clears `nmi_pending`.
  - A hijacked BRK still pushes B=1, and `kind` stays at 1.
- **NMI detection.** `nmi_n` is registered every cycle. A registered 1 followed by a 0 sets `nmi_pending`.
  - `nmi_pending` stays set until it is consumed; it is not cleared by `nmi_n` returning high.
  - An edge that arrives after VEC_LO stays pending for the next boundary.
- **IRQ.** IRQ is not latched. If `irq_n` deasserts before a boundary, no IRQ is taken.
- **Idle outputs.** In IDLE: `we`=0, `set_i`=0, `addr`=0, `wdata`=0.

## Timing
- **Reset.** While `rst` is asserted, all of the following hold, asynchronously:
  - state=IDLE.
  - `addr`=0, `wdata`=0, `we`=0, `sp_out`=0, `sp_load`=0.
  - `set_i`=0, `pc_out`=0, `pc_load`=0, `busy`=0, `done`=0, `kind`=0.
  - `nmi_pending`=0, and the registered `nmi_n` value is 1.
- **Reset mid-sequence.** The sequence aborts with no further writes or pulses.
- **Latency.** The request edge is cycle 0. Cycles 1–5 are PUSH_PCH through VEC_HI. `done` is high in cycle 6.
- **Busy.** `busy`=1 in cycles 1–5.
- **Back-to-back sequences.** `boundary` is ignored while `busy`. A new sequence can start in the `done` cycle if `boundary`=1.
- **NMI latency.** An NMI falling edge is visible as pending one cycle after it is sampled.

## Configuration
- `MOS6502S_NMI_HIJACK_EN` defined: NMI hijack works as described under Operation.
- `MOS6502S_NMI_HIJACK_EN` undefined:
  - The vector is chosen solely by `kind`.
  - `nmi_pending` is cleared only by an NMI sequence entering VEC_LO.
  - An NMI that arrives during a BRK/IRQ sequence is taken at the next boundary.

## Test plan
- **BRK.** `sp_in`=8'hFD, `pc_in`=16'h1234, `p_in`=8'h00, memory[FFFE..FFFF]=00,80, `brk_req` at `boundary`.
  - Writes 12@01FD, 34@01FC, 30@01FB.
  - `set_i` in cycle 3; `pc_out`=8000 and `sp_out`=FA at `done` in cycle 6.
- **IRQ masking.** `irq_n`=0 with `i_flag`=1: no start. With `i_flag`=0 and `p_in`=8'h00: the pushed P is 8'h20.
- **NMI edge.** `nmi_n` falls and is held low across two boundaries.
  - Exactly one sequence runs, with vector FFFA.
  - A second falling edge triggers a second sequence.
- **Hijack.** An NMI edge during PUSH_PCL of an IRQ sequence:
  - With the macro: vector FFFA and pending cleared.
  - Without the macro: vector FFFE, then an NMI sequence at the next boundary.
- **Wrap.** `sp_in`=8'h01 gives writes to 0101, 0100, 01FF, and `sp_out`=FE.
- **Reset.** `rst` asserted during PUSH_P: `we`=0 immediately, then IDLE with no `done` pulse. A pending NMI is lost.
